// File: rtl/noc_pkg.sv
// noc_pkg: header flit layout, packet descriptor type and injector FSM states.
// Shared by manycore_noc_injector and its sub-modules.
package noc_pkg;

   localparam int HDR_WIDTH = 64;

   localparam int HDR_CHIPID_LSB  = 50;
   localparam int HDR_CHIPID_W    = 14;
   localparam int HDR_XPOS_LSB    = 42;
   localparam int HDR_XPOS_W      = 8;
   localparam int HDR_YPOS_LSB    = 34;
   localparam int HDR_YPOS_W      = 8;
   localparam int HDR_FBITS_LSB   = 30;
   localparam int HDR_FBITS_W     = 4;
   localparam int HDR_LEN_LSB     = 22;
   localparam int HDR_LEN_W       = 8;
   localparam int HDR_MSGTYPE_LSB = 14;
   localparam int HDR_MSGTYPE_W   = 8;
   localparam int HDR_MSHRID_LSB  = 6;
   localparam int HDR_MSHRID_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2
   } inj_state_t;

   // Everything latched from a descriptor except the payload length.
   typedef struct packed {
      logic [HDR_CHIPID_W-1:0]  chipid;
      logic [HDR_XPOS_W-1:0]    x;
      logic [HDR_YPOS_W-1:0]    y;
      logic [HDR_FBITS_W-1:0]   fbits;
      logic [HDR_MSGTYPE_W-1:0] msg_type;
      logic [HDR_MSHRID_W-1:0]  mshrid;
      logic [31:0]              seed;
   } desc_t;

   // Assemble the header flit; the low six bits are always zero.
   function automatic logic [HDR_WIDTH-1:0] build_header(input desc_t d,
                                                         input logic [HDR_LEN_W-1:0] len);
      logic [HDR_WIDTH-1:0] h;
      h = '0;
      h[HDR_CHIPID_LSB  +: HDR_CHIPID_W]  = d.chipid;
      h[HDR_XPOS_LSB    +: HDR_XPOS_W]    = d.x;
      h[HDR_YPOS_LSB    +: HDR_YPOS_W]    = d.y;
      h[HDR_FBITS_LSB   +: HDR_FBITS_W]   = d.fbits;
      h[HDR_LEN_LSB     +: HDR_LEN_W]     = len;
      h[HDR_MSGTYPE_LSB +: HDR_MSGTYPE_W] = d.msg_type;
      h[HDR_MSHRID_LSB  +: HDR_MSHRID_W]  = d.mshrid;
      return h;
   endfunction

endpackage

// File: rtl/manycore_noc_injector_if.sv
// manycore_noc_injector_if: descriptor request handshake plus the NoC
// valid/data/yummy channel. master = traffic source, slave = injector.
interface manycore_noc_injector_if #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic [13:0]           req_chipid;
   logic [7:0]            req_x;
   logic [7:0]            req_y;
   logic [3:0]            req_fbits;
   logic [LEN_WIDTH-1:0]  req_len;
   logic [7:0]            req_msg_type;
   logic [7:0]            req_mshrid;
   logic [31:0]           req_seed;
   logic                  noc_valid;
   logic [DATA_WIDTH-1:0] noc_data;
   logic                  noc_yummy;

   modport master (
      output req_valid, req_chipid, req_x, req_y, req_fbits, req_len,
             req_msg_type, req_mshrid, req_seed, noc_yummy,
      input  req_ready, noc_valid, noc_data
   );

   modport slave (
      input  req_valid, req_chipid, req_x, req_y, req_fbits, req_len,
             req_msg_type, req_mshrid, req_seed, noc_yummy,
      output req_ready, noc_valid, noc_data
   );
endinterface

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: tracks free slots in the downstream input buffer.
// Starts full, saturates at CREDITS. With NOC_INJECTOR_CREDIT_CHECK_EN
// defined, a yummy arriving at full credits raises a sticky overflow flag;
// otherwise overflow is tied low.
module noc_credit_counter #(
   parameter int CREDITS = 8,
   parameter int CW      = $clog2(CREDITS + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic send,
   input  logic yummy,
   output logic has_credit,
   output logic overflow
);

   localparam logic [CW-1:0] FULL = CW'(CREDITS);

   logic [CW-1:0] credits;
   logic          at_full;

   assign at_full    = (credits == FULL);
   assign has_credit = (credits != '0);

   // Send and yummy in the same cycle cancel; a yummy at full is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= FULL;
      end else if (send && !yummy && has_credit) begin
         credits <= credits - CW'(1);
      end else if (yummy && !send && !at_full) begin
         credits <= credits + CW'(1);
      end
   end

`ifdef NOC_INJECTOR_CREDIT_CHECK_EN
   logic overflow_q;

   // Sticky record of a credit returned when none were outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (yummy && at_full) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

`ifndef SYNTHESIS
   // Announce each overflow event so it can be located in a log.
   always_ff @(posedge clk) begin
      if (!rst && yummy && at_full) begin
         $display("noc_credit_counter: credit overflow at time %0t", $time);
      end
   end
`endif
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: rtl/manycore_noc_injector.sv
// manycore_noc_injector: takes one packet descriptor, sends its header flit
// and len payload flits {seed, k} on a NoC channel under valid/yummy credit
// flow control. Optional macro: NOC_INJECTOR_CREDIT_CHECK_EN enables the
// sticky err_credit overflow flag.
module manycore_noc_injector
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CREDITS    = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   manycore_noc_injector_if.slave  bus,
   output logic                    busy,
   output logic [31:0]             pkt_count,
   output logic                    err_credit
);

   inj_state_t            state_q, state_d;
   desc_t                 desc_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [31:0]           pkt_count_q;
   logic                  load_desc;
   logic                  send;
   logic                  pkt_done;
   logic                  has_credit;

   noc_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .send       (send),
      .yummy      (bus.noc_yummy),
      .has_credit (has_credit),
      .overflow   (err_credit)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and flit selection; a flit goes out only while credit remains.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      valid_d   = 1'b0;
      data_d    = data_q;
      load_desc = 1'b0;
      send      = 1'b0;
      pkt_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               load_desc = 1'b1;
               state_d   = ST_HEAD;
            end
         end
         ST_HEAD: begin
            if (has_credit) begin
               send    = 1'b1;
               valid_d = 1'b1;
               data_d  = DATA_WIDTH'(build_header(desc_q, HDR_LEN_W'(len_q)));
               if (len_q != '0) begin
                  state_d = ST_BODY;
                  idx_d   = LEN_WIDTH'(1);
               end else begin
                  state_d  = ST_IDLE;
                  pkt_done = 1'b1;
               end
            end
         end
         ST_BODY: begin
            if (has_credit) begin
               send    = 1'b1;
               valid_d = 1'b1;
               data_d  = DATA_WIDTH'({desc_q.seed, 32'(idx_q)});
               if (idx_q == len_q) begin
                  state_d  = ST_IDLE;
                  pkt_done = 1'b1;
               end else begin
                  idx_d = idx_q + LEN_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Descriptor latch, flit index, registered channel outputs and packet count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         desc_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         pkt_count_q <= '0;
      end else begin
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         if (load_desc) begin
            desc_q.chipid   <= bus.req_chipid;
            desc_q.x        <= bus.req_x;
            desc_q.y        <= bus.req_y;
            desc_q.fbits    <= bus.req_fbits;
            desc_q.msg_type <= bus.req_msg_type;
            desc_q.mshrid   <= bus.req_mshrid;
            desc_q.seed     <= bus.req_seed;
            len_q           <= bus.req_len;
         end
         if (pkt_done) begin
            pkt_count_q <= pkt_count_q + 32'd1;
         end
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign bus.noc_valid = valid_q;
   assign bus.noc_data  = data_q;
   assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_manycore_noc_injector.sv
// tb_manycore_noc_injector: scoreboard bench. Each descriptor pushes its
// expected flits into a queue; a monitor pops and compares every flit seen
// on the channel and models the downstream buffer returning yummies.
`timescale 1ns/1ps
module tb_manycore_noc_injector;

   localparam int DATA_WIDTH = 64;
   localparam int CREDITS    = 8;
   localparam int LEN_WIDTH  = 8;

   typedef struct {
      logic [63:0] data;
      bit          last;
   } exp_flit_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [31:0] pkt_count;
   logic        err_credit;

   manycore_noc_injector_if #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

   manycore_noc_injector #(
      .DATA_WIDTH (DATA_WIDTH),
      .CREDITS    (CREDITS),
      .LEN_WIDTH  (LEN_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .pkt_count  (pkt_count),
      .err_credit (err_credit)
   );

   always #5 clk = ~clk;

   exp_flit_t sb[$];
   int        ret_due[$];
   int        total = 0;
   int        bad = 0;
   int        cyc = 0;
   int        tb_cred = CREDITS;
   int        exp_pkts = 0;
   bit        auto_yummy = 1'b1;
   bit        rand_skip = 1'b0;
   int        yummy_delay = 1;
   int        manual_pulse = 0;
   logic      y_seen = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] modelHeader(input int chipid, input int x, input int y,
                                               input int fbits, input int len, input int msg,
                                               input int mshr);
      logic [63:0] h;
      h = (64'(chipid) << 50) | (64'(x) << 42) | (64'(y) << 34) | (64'(fbits) << 30)
        | (64'(len) << 22) | (64'(msg) << 14) | (64'(mshr) << 6);
      return h;
   endfunction

   // Issue one descriptor, wait for acceptance, and queue its expected flits.
   task automatic applyStimulus(input int chipid, input int x, input int y, input int fbits,
                                input int len, input int msg, input int mshr,
                                input logic [31:0] seed);
      exp_flit_t f;
      int guard = 0;
      bus.req_chipid   = 14'(chipid);
      bus.req_x        = 8'(x);
      bus.req_y        = 8'(y);
      bus.req_fbits    = 4'(fbits);
      bus.req_len      = LEN_WIDTH'(len);
      bus.req_msg_type = 8'(msg);
      bus.req_mshrid   = 8'(mshr);
      bus.req_seed     = seed;
      bus.req_valid    = 1'b1;
      while (bus.req_ready !== 1'b1 && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 500) checkOutput("req_ready_timeout", 64'(bus.req_ready), 64'd1);
      f.data = modelHeader(chipid, x, y, fbits, len, msg, mshr);
      f.last = (len == 0);
      sb.push_back(f);
      for (int k = 1; k <= len; k++) begin
         f.data = {seed, 32'(k)};
         f.last = (k == len);
         sb.push_back(f);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("[TB] FAIL idle_timeout: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
      end
   endtask

   task automatic waitCredits(input int budget);
      int n = 0;
      while (tb_cred != CREDITS && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("[TB] FAIL credit_return_timeout: credits=%0d, required %0d", tb_cred, CREDITS);
      end
   endtask

   // Capture the yummy the DUT saw on each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         y_seen = bus.noc_yummy;
      end
   end

   // Downstream buffer model: return one credit per received flit.
   initial begin
      bus.noc_yummy = 1'b0;
      forever begin
         @(posedge clk); #2;
         cyc++;
         bus.noc_yummy = 1'b0;
         if (rst !== 1'b1) begin
            if (manual_pulse > 0) begin
               bus.noc_yummy = 1'b1;
               manual_pulse--;
               if (ret_due.size() > 0) void'(ret_due.pop_front());
            end else if (auto_yummy && ret_due.size() > 0 && ret_due[0] <= cyc
                         && (!rand_skip || $urandom_range(0, 3) != 0)) begin
               bus.noc_yummy = 1'b1;
               void'(ret_due.pop_front());
            end
         end
      end
   end

   // Monitor: compare each flit with the scoreboard and track credits.
   initial begin
      exp_flit_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (bus.noc_valid === 1'b1) begin
               total++;
               if (tb_cred <= 0) begin
                  bad++;
                  $display("[TB] FAIL credit_guard: flit sent with %0d credits, required >0", tb_cred);
               end
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_flit: got %h, required no flit", bus.noc_data);
               end else begin
                  e = sb.pop_front();
                  checkOutput("flit_data", bus.noc_data, e.data);
                  if (e.last) begin
                     exp_pkts++;
                     checkOutput("pkt_count", 64'(pkt_count), 64'(exp_pkts));
                  end
               end
               ret_due.push_back(cyc + yummy_delay);
            end
            tb_cred = tb_cred + (y_seen === 1'b1 ? 1 : 0) - (bus.noc_valid === 1'b1 ? 1 : 0);
            if (tb_cred > CREDITS) tb_cred = CREDITS;
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      int len;
      bit exp_err;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_chipid = '0; bus.req_x = '0; bus.req_y = '0; bus.req_fbits = '0;
      bus.req_len = '0; bus.req_msg_type = '0; bus.req_mshrid = '0; bus.req_seed = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("rst_noc_valid", 64'(bus.noc_valid), 64'd0);
      checkOutput("rst_noc_data", bus.noc_data, 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
      checkOutput("rst_err_credit", 64'(err_credit), 64'd0);
      rst = 1'b0;

      $display("[TB] example packet, yummy after 1 cycle");
      applyStimulus(0, 1, 2, 0, 2, 8'h10, 3, 32'hA5A5A5A5);
      checkOutput("accept_busy", 64'(busy), 64'd1);
      checkOutput("accept_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      checkOutput("header_timing", 64'(bus.noc_valid), 64'd1);
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("example_req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("example_pkt_count", 64'(pkt_count), 64'd1);
      checkOutput("example_busy", 64'(busy), 64'd0);
      waitCredits(100);

      $display("[TB] zero-length packet");
      applyStimulus(5, 3, 4, 1, 0, 8'h22, 9, 32'h12345678);
      @(posedge clk); #1;
      checkOutput("len0_header", 64'(bus.noc_valid), 64'd1);
      checkOutput("len0_idle", 64'(busy), 64'd0);
      checkOutput("len0_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      checkOutput("len0_one_flit", 64'(bus.noc_valid), 64'd0);
      waitCredits(100);

      $display("[TB] reset in the middle of a payload");
      applyStimulus(7, 6, 5, 2, 20, 8'h31, 4, 32'hCAFEF00D);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("midbody_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_noc_valid", 64'(bus.noc_valid), 64'd0);
      checkOutput("midrst_noc_data", bus.noc_data, 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("midrst_pkt_count", 64'(pkt_count), 64'd0);
      sb.delete();
      ret_due.delete();
      tb_cred = CREDITS;
      exp_pkts = 0;
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] no credit return, len=10");
      auto_yummy = 1'b0;
      applyStimulus(1, 2, 3, 4, 10, 8'h40, 5, 32'h0BADBEEF);
      cnt = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (bus.noc_valid === 1'b1) cnt++;
      end
      checkOutput("stall_flit_count", 64'(cnt), 64'd8);
      checkOutput("stall_noc_valid", 64'(bus.noc_valid), 64'd0);
      checkOutput("stall_busy", 64'(busy), 64'd1);
      manual_pulse = 1;
      @(posedge clk); #1;
      checkOutput("yummy_cycle_no_flit", 64'(bus.noc_valid), 64'd0);
      @(posedge clk); #1;
      checkOutput("yummy_next_flit", 64'(bus.noc_valid), 64'd1);
      @(posedge clk); #1;
      checkOutput("yummy_single_flit", 64'(bus.noc_valid), 64'd0);
      auto_yummy = 1'b1;
      waitIdle(400);
      waitCredits(400);

      $display("[TB] randomized packets");
      rand_skip = 1'b1;
      for (int p = 0; p < 20; p++) begin
         yummy_delay = int'($urandom_range(1, 4));
         len = int'($urandom_range(0, 12));
         applyStimulus(int'($urandom_range(0, 16383)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), len,
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $urandom);
         repeat (int'($urandom_range(0, 3))) begin @(posedge clk); #1; end
      end
      waitIdle(2000);
      rand_skip = 1'b0;
      waitCredits(400);
      checkOutput("random_pkt_count", 64'(pkt_count), 64'(exp_pkts));

      $display("[TB] yummy at full credits");
`ifdef NOC_INJECTOR_CREDIT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      checkOutput("err_before_overflow", 64'(err_credit), 64'd0);
      manual_pulse = 1;
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("err_credit_set", 64'(err_credit), 64'(exp_err));
      repeat (5) begin @(posedge clk); #1; end
      checkOutput("err_credit_sticky", 64'(err_credit), 64'(exp_err));
      applyStimulus(2, 2, 2, 2, 3, 8'h55, 6, 32'h01020304);
      waitIdle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
